// File: rtl/iic_target_pkg.sv
// -----------------------------------------------------------------------------
// iic_target_pkg
//   Shared types and constants for the AD9980-style I2C register target.
//   - state_t   : target FSM states
//   - BIT_CNT_W : width of the per-byte bit counter (counts 0..8)
//   - BIT_ACK / BIT_NACK : SDA levels of the acknowledge bit
//   - shift_in  : MSB-first serial shift helper
// -----------------------------------------------------------------------------
package iic_target_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RACK_WAIT
    } state_t;

    localparam int BIT_CNT_W = 4;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = 4'd7;
    localparam logic [BIT_CNT_W-1:0] BYTE_BITS = 4'd8;

    localparam logic BIT_ACK  = 1'b0;
    localparam logic BIT_NACK = 1'b1;

    // Bytes arrive MSB first: each sampled bit enters at the bottom.
    function automatic logic [7:0] shift_in(input logic [7:0] sr, input logic b);
        return {sr[6:0], b};
    endfunction

endpackage

// File: rtl/iic_bus_sync.sv
// -----------------------------------------------------------------------------
// iic_bus_sync
//   Brings SCL/SDA into the Clk domain and decodes bus events.
//   Ports:
//     clk, rst_n        : system clock, asynchronous active-low reset
//     scl, sda          : raw bus lines
//     scl_rise/scl_fall : one-cycle pulses on synchronized SCL edges
//     start_det         : SDA fell while SCL high
//     stop_det          : SDA rose while SCL high
//     sda_smp           : synchronized SDA level
// -----------------------------------------------------------------------------
module iic_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_smp
);

    logic scl_p0, scl_p1, scl_p2;
    logic sda_p0, sda_p1, sda_p2;

    // Flops reset to the idle bus level (both lines high) so that leaving
    // reset never looks like an edge or a bus condition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_p0 <= 1'b1;
            scl_p1 <= 1'b1;
            scl_p2 <= 1'b1;
            sda_p0 <= 1'b1;
            sda_p1 <= 1'b1;
            sda_p2 <= 1'b1;
        end else begin
            // p0 -> p1: two-flop synchronizer
            scl_p0 <= scl;
            sda_p0 <= sda;
            scl_p1 <= scl_p0;
            sda_p1 <= sda_p0;
            // p1 -> p2: previous value for edge detection
            scl_p2 <= scl_p1;
            sda_p2 <= sda_p1;
        end
    end

    assign scl_rise  =  scl_p1 & ~scl_p2;
    assign scl_fall  = ~scl_p1 &  scl_p2;
    // SCL must be high in both samples so an SCL edge coinciding with an
    // SDA change is never taken as START/STOP.
    assign start_det =  scl_p1 &  scl_p2 &  sda_p2 & ~sda_p1;
    assign stop_det  =  scl_p1 &  scl_p2 & ~sda_p2 &  sda_p1;
    assign sda_smp   =  sda_p1;

endmodule

// File: rtl/iic_target_regfile.sv
// -----------------------------------------------------------------------------
// iic_target_regfile
//   I2C target modelling the AD9980 register interface. Holds 2**ADDR_W
//   bytes; register 0 is read-only and returns CHIP_ID. Writes set the
//   pointer from the first data byte and auto-increment; reads stream from
//   the pointer with auto-increment while the master ACKs.
//   Ports:
//     Clk, Reset_n : system clock (>= 8x SCL), async active-low reset
//     SCL          : bus clock (never stretched)
//     SDA          : open-drain data, driven 0 or released
//     Wr_valid     : one-Clk pulse per accepted data write
//     Wr_addr      : register index of the reported write
//     Wr_data      : data byte of the reported write
//     Sys_addr     : system-side read index
//     Sys_data     : reg[Sys_addr], one Clk latency
//     Busy         : high from address match until STOP / back to IDLE
// -----------------------------------------------------------------------------
module iic_target_regfile
    import iic_target_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h4C,
    parameter int         ADDR_W   = 6,
    parameter logic [7:0] CHIP_ID  = 8'h03
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              SCL,
    inout  wire               SDA,
    output logic              Wr_valid,
    output logic [ADDR_W-1:0] Wr_addr,
    output logic [7:0]        Wr_data,
    input  logic [ADDR_W-1:0] Sys_addr,
    output logic [7:0]        Sys_data,
    output logic              Busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic                 scl_rise, scl_fall, start_det, stop_det, sda_smp;
    state_t               state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [7:0]           shift;
    logic [ADDR_W-1:0]    ptr;
    logic [ADDR_W-1:0]    ptr_nxt;
    logic                 rw_bit;
    logic                 sda_oe;
    logic [7:0]           rx_byte;
    logic [7:0]           regs [DEPTH];

    iic_bus_sync u_sync (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .scl       (SCL),
        .sda       (SDA),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_smp   (sda_smp)
    );

    // Open drain: a 1 is always expressed by releasing the line.
    assign SDA = sda_oe ? 1'b0 : 1'bz;

    assign rx_byte = shift_in(shift, sda_smp);
    assign ptr_nxt = ptr + ADDR_W'(1);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            ptr      <= '0;
            rw_bit   <= 1'b0;
            sda_oe   <= 1'b0;
            Busy     <= 1'b0;
            Wr_valid <= 1'b0;
            Wr_addr  <= '0;
            Wr_data  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= (i == 0) ? CHIP_ID : 8'h00;
            end
        end else begin
            Wr_valid <= 1'b0;

            if (stop_det) begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
                Busy   <= 1'b0;
            end else if (start_det) begin
                // Repeated START keeps ptr so a pointer write can be
                // followed by a restart-read.
                state   <= ST_ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        sda_oe <= 1'b0;
                    end

                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift <= rx_byte;
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    state  <= ST_ADDR_ACK;
                                    rw_bit <= rx_byte[0];
                                    Busy   <= 1'b1;
                                end else begin
                                    state <= ST_IDLE;
                                    Busy  <= 1'b0;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                            end
                        end
                    end

                    // In the ACK states sda_oe doubles as the phase flag:
                    // the first SCL fall starts pulling low, the fall after
                    // the 9th clock ends the ACK.
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                bit_cnt <= '0;
                                if (rw_bit) begin
                                    // Bit 7 goes out on this same fall.
                                    shift  <= regs[ptr];
                                    sda_oe <= ~regs[ptr][7];
                                    state  <= ST_RDATA;
                                end else begin
                                    sda_oe <= 1'b0;
                                    state  <= ST_PTR;
                                end
                            end
                        end
                    end

                    ST_PTR: begin
                        if (scl_rise) begin
                            shift <= rx_byte;
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
                                ptr     <= rx_byte[ADDR_W-1:0];
                                state   <= ST_PTR_ACK;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                            end
                        end
                    end

                    ST_PTR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= ST_WDATA;
                            end
                        end
                    end

                    ST_WDATA: begin
                        if (scl_rise) begin
                            shift <= rx_byte;
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
                                state   <= ST_WDATA_ACK;
                                // Register 0 is read-only; the byte is still ACKed.
                                if (ptr != '0) begin
                                    regs[ptr] <= rx_byte;
                                    Wr_valid  <= 1'b1;
                                    Wr_addr   <= ptr;
                                    Wr_data   <= rx_byte;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                            end
                        end
                    end

                    ST_WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                ptr     <= ptr_nxt;
                                state   <= ST_WDATA;
                            end
                        end
                    end

                    // bit_cnt counts SCL rises already seen by the master.
                    // At 0 the byte is freshly loaded and bit 7 still has to
                    // go out; from 1..7 the next lower bit follows each fall.
                    ST_RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end else if (scl_fall) begin
                            if (bit_cnt == BYTE_BITS) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= ST_RACK_WAIT;
                            end else if (bit_cnt == '0) begin
                                sda_oe <= ~shift[7];
                            end else begin
                                sda_oe <= ~shift[6];
                                shift  <= {shift[6:0], 1'b0};
                            end
                        end
                    end

                    ST_RACK_WAIT: begin
                        if (scl_rise) begin
                            if (sda_smp == BIT_ACK) begin
                                ptr     <= ptr_nxt;
                                shift   <= regs[ptr_nxt];
                                bit_cnt <= '0;
                                state   <= ST_RDATA;
                            end else begin
                                state <= ST_IDLE;
                                Busy  <= 1'b0;
                            end
                        end
                    end

                    default: begin
                        state  <= ST_IDLE;
                        sda_oe <= 1'b0;
                        Busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Plain registered read: a same-cycle bus write to the same index is
    // seen here only on the following cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Sys_data <= '0;
        end else begin
            Sys_data <= regs[Sys_addr];
        end
    end

endmodule

// File: tb/tb_iic_target_regfile.sv
module tb_iic_target_regfile;

    localparam int Q = 40;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_low = 1'b0;
    wire        sda_bus;
    logic       Wr_valid;
    logic [5:0] Wr_addr;
    logic [7:0] Wr_data;
    logic [5:0] Sys_addr = 6'd0;
    logic [7:0] Sys_data;
    logic       Busy;

    assign sda_bus = sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #5 Clk = ~Clk;

    iic_target_regfile #(
        .DEV_ADDR (7'h4C),
        .ADDR_W   (6),
        .CHIP_ID  (8'h03)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .SCL      (scl_m),
        .SDA      (sda_bus),
        .Wr_valid (Wr_valid),
        .Wr_addr  (Wr_addr),
        .Wr_data  (Wr_data),
        .Sys_addr (Sys_addr),
        .Sys_data (Sys_data),
        .Busy     (Busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Observed write sideband and bus monitors
    logic [5:0] got_wa[$];
    logic [7:0] got_wd[$];
    logic [5:0] exp_wa[$];
    logic [7:0] exp_wd[$];
    logic       sda_low_seen = 1'b0;
    logic       busy_seen    = 1'b0;

    always @(negedge Clk) begin
        if (Wr_valid) begin
            got_wa.push_back(Wr_addr);
            got_wd.push_back(Wr_data);
        end
        if (sda_bus == 1'b0 && !sda_low) sda_low_seen = 1'b1;
        if (Busy) busy_seen = 1'b1;
    end

    // Reference model: byte array plus pointer, updated per transaction rule
    logic [7:0] m_regs[64];
    logic [5:0] m_ptr;

    function automatic void m_reset();
        for (int i = 0; i < 64; i++) m_regs[i] = 8'h00;
        m_regs[0] = 8'h03;
        m_ptr = 6'd0;
    endfunction

    function automatic void m_set_ptr(input logic [7:0] b);
        m_ptr = 6'(int'(b) % 64);
    endfunction

    function automatic void m_advance();
        m_ptr = 6'((int'(m_ptr) + 1) % 64);
    endfunction

    function automatic void m_write(input logic [7:0] d);
        if (m_ptr != 6'd0) begin
            m_regs[m_ptr] = d;
            exp_wa.push_back(m_ptr);
            exp_wd.push_back(d);
        end
        m_advance();
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_writes(input string name);
        check({name, " count"}, got_wa.size(), exp_wa.size());
        for (int i = 0; i < got_wa.size() && i < exp_wa.size(); i++) begin
            check({name, " addr"}, got_wa[i], exp_wa[i]);
            check({name, " data"}, got_wd[i], exp_wd[i]);
        end
        got_wa.delete();
        got_wd.delete();
        exp_wa.delete();
        exp_wd.delete();
    endtask

    // Bus master primitives: SDA only changes a quarter period after SCL falls
    task automatic put_bit(input logic b, output logic s);
        sda_low = ~b;
        #Q;
        scl_m = 1'b1;
        #Q;
        s = sda_bus;
        #Q;
        scl_m = 1'b0;
        #Q;
    endtask

    task automatic bus_start();
        sda_low = 1'b0;
        #Q;
        scl_m = 1'b1;
        #Q;
        sda_low = 1'b1;
        #Q;
        scl_m = 1'b0;
        #Q;
    endtask

    task automatic bus_stop();
        sda_low = 1'b1;
        #Q;
        scl_m = 1'b1;
        #Q;
        sda_low = 1'b0;
        #(2*Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) put_bit(b[i], s);
        put_bit(1'b1, s);
        ack = (s == 1'b0);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            put_bit(1'b1, s);
            d[i] = s;
        end
        put_bit(nack, s);
    endtask

    task automatic sys_read(input logic [5:0] idx, output logic [7:0] d);
        @(negedge Clk);
        Sys_addr = idx;
        @(posedge Clk);
        #1;
        d = Sys_data;
    endtask

    typedef struct {
        logic [7:0] addr_byte;
        logic [7:0] ptr_byte;
        logic [7:0] data_byte;
        logic       exp_ack;
        logic       exp_wr;
        logic [5:0] exp_idx;
        logic [7:0] exp_sys;
    } vec_t;

    vec_t vecs[5];

    initial begin : watchdog
        #(5_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t       v;
        logic       ack;
        logic       s;
        logic [7:0] d;
        logic [7:0] pb;
        logic [5:0] p;
        int         op;
        int         len;
        int         idx;

        vecs[0] = '{8'h98, 8'h05, 8'hA5, 1'b1, 1'b1, 6'h05, 8'hA5};
        vecs[1] = '{8'h98, 8'hC7, 8'h3C, 1'b1, 1'b1, 6'h07, 8'h3C};
        vecs[2] = '{8'h98, 8'h00, 8'h7E, 1'b1, 1'b0, 6'h00, 8'h03};
        vecs[3] = '{8'h9A, 8'h09, 8'h11, 1'b0, 1'b0, 6'h09, 8'h00};
        vecs[4] = '{8'h98, 8'hBF, 8'hFF, 1'b1, 1'b1, 6'h3F, 8'hFF};

        // Reset state
        #1 Reset_n = 1'b0;
        m_reset();
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst sda released", sda_bus, 1'b1);
        check("rst busy", Busy, 1'b0);
        check("rst wr_valid", Wr_valid, 1'b0);
        check("rst wr_addr", Wr_addr, 6'd0);
        check("rst wr_data", Wr_data, 8'd0);
        check("rst sys_data", Sys_data, 8'd0);
        Reset_n = 1'b1;
        sys_read(6'h00, d);
        check("rst reg0 chip id", d, 8'h03);
        sys_read(6'h05, d);
        check("rst reg5", d, 8'h00);
        got_wa.delete();
        got_wd.delete();

        // Table-driven single-byte writes
        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            sda_low_seen = 1'b0;
            busy_seen    = 1'b0;
            bus_start();
            send_byte(v.addr_byte, ack);
            check("vec addr ack", ack, v.exp_ack);
            if (v.exp_ack) begin
                check("vec busy", Busy, 1'b1);
                send_byte(v.ptr_byte, ack);
                check("vec ptr ack", ack, 1'b1);
                send_byte(v.data_byte, ack);
                check("vec data ack", ack, 1'b1);
            end else begin
                check("vec mismatch sda", sda_low_seen, 1'b0);
                check("vec mismatch busy", busy_seen, 1'b0);
            end
            bus_stop();
            check("vec busy after stop", Busy, 1'b0);
            if (v.exp_wr) begin
                exp_wa.push_back(v.exp_idx);
                exp_wd.push_back(v.data_byte);
                m_regs[v.exp_idx] = v.data_byte;
            end
            check_writes("vec wr");
            sys_read(v.exp_idx, d);
            check("vec sys_data", d, v.exp_sys);
        end

        // Write burst with auto-increment
        bus_start();
        send_byte(8'h98, ack); check("burst addr ack", ack, 1'b1);
        send_byte(8'h10, ack); check("burst ptr ack", ack, 1'b1);
        m_set_ptr(8'h10);
        send_byte(8'hAA, ack); check("burst d0 ack", ack, 1'b1);
        m_write(8'hAA);
        send_byte(8'h55, ack); check("burst d1 ack", ack, 1'b1);
        m_write(8'h55);
        bus_stop();
        check("burst exp first", exp_wa[0], 6'h10);
        check_writes("burst wr");
        sys_read(6'h11, d);
        check("burst sys 0x11", d, 8'h55);

        // Pointer 0x3F then restart-read across the wrap
        bus_start();
        send_byte(8'h98, ack); check("rd addr ack", ack, 1'b1);
        send_byte(8'h3F, ack); check("rd ptr ack", ack, 1'b1);
        m_set_ptr(8'h3F);
        bus_start();
        send_byte(8'h99, ack); check("rd raddr ack", ack, 1'b1);
        recv_byte(1'b0, d); check("rd byte 3f", d, m_regs[m_ptr]); m_advance();
        recv_byte(1'b0, d); check("rd byte 00 chip id", d, 8'h03); m_advance();
        recv_byte(1'b1, d); check("rd byte 01", d, m_regs[m_ptr]);
        check("rd sda released after nack", sda_bus, 1'b1);
        #(3*Q);
        check("rd sda still released", sda_bus, 1'b1);
        check("rd busy after nack", Busy, 1'b0);
        bus_stop();
        check_writes("rd no wr");

        // STOP after four data bits
        bus_start();
        send_byte(8'h98, ack); check("stopmid addr ack", ack, 1'b1);
        send_byte(8'h20, ack); check("stopmid ptr ack", ack, 1'b1);
        put_bit(1'b1, s); put_bit(1'b0, s); put_bit(1'b1, s); put_bit(1'b1, s);
        bus_stop();
        check("stopmid busy", Busy, 1'b0);
        check_writes("stopmid no wr");
        bus_start();
        send_byte(8'h98, ack); check("after stop addr ack", ack, 1'b1);
        send_byte(8'h20, ack); check("after stop ptr ack", ack, 1'b1);
        m_set_ptr(8'h20);
        send_byte(8'hC3, ack); check("after stop data ack", ack, 1'b1);
        m_write(8'hC3);
        bus_stop();
        check_writes("after stop wr");

        // Randomized transactions against the model
        for (int it = 0; it < 16; it++) begin
            op  = $urandom_range(0, 2);
            len = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) p = 6'($urandom_range(60, 63));
            else                            p = 6'($urandom_range(0, 63));
            pb = {2'($urandom_range(0, 3)), p};
            bus_start();
            send_byte(8'h98, ack); check("rnd addr ack", ack, 1'b1);
            send_byte(pb, ack);    check("rnd ptr ack", ack, 1'b1);
            m_set_ptr(pb);
            if (op != 2) begin
                for (int j = 0; j < len; j++) begin
                    d = 8'($urandom);
                    send_byte(d, ack);
                    check("rnd data ack", ack, 1'b1);
                    m_write(d);
                end
            end else begin
                bus_start();
                send_byte(8'h99, ack); check("rnd raddr ack", ack, 1'b1);
                for (int j = 0; j < len; j++) begin
                    recv_byte((j == len - 1) ? 1'b1 : 1'b0, d);
                    check("rnd read", d, m_regs[m_ptr]);
                    if (j < len - 1) m_advance();
                end
            end
            bus_stop();
            check_writes("rnd wr");
            idx = $urandom_range(0, 63);
            sys_read(6'(idx), d);
            check("rnd sys_data", d, m_regs[idx]);
        end

        // Reset while the target holds SDA low (bit 7 of CHIP_ID is 0)
        bus_start();
        send_byte(8'h98, ack); check("rstmid addr ack", ack, 1'b1);
        send_byte(8'h00, ack); check("rstmid ptr ack", ack, 1'b1);
        bus_start();
        send_byte(8'h99, ack); check("rstmid raddr ack", ack, 1'b1);
        check("rstmid target drives low", sda_bus, 1'b0);
        check("rstmid busy before", Busy, 1'b1);
        Reset_n = 1'b0;
        #1;
        check("rstmid sda released", sda_bus, 1'b1);
        check("rstmid busy", Busy, 1'b0);
        check("rstmid wr_valid", Wr_valid, 1'b0);
        check("rstmid wr_addr", Wr_addr, 6'd0);
        check("rstmid wr_data", Wr_data, 8'd0);
        check("rstmid sys_data", Sys_data, 8'd0);
        m_reset();
        @(negedge Clk);
        Reset_n = 1'b1;
        bus_stop();
        sys_read(6'h20, d);
        check("rstmid reg cleared", d, 8'h00);
        got_wa.delete();
        got_wd.delete();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
